// File: rtl/acc_mem_pkg.sv
// Shared types and constants for the accelerator memory responder.
// Holds the read/write FSM state encodings, bus widths and the
// saturating-increment helper used by the optional statistics counters.
package acc_mem_pkg;

    // Data word width of the memory and both data buses
    localparam int DATA_W    = 32;
    // Byte-address width on the read/write request ports
    localparam int ADDR_W    = 64;
    // Width of the rd_ready/wr_ready handshake outputs (value 0 or 1 only)
    localparam int READY_W   = 64;
    // Latency counters cover the legal latency range of 1..15 cycles
    localparam int LAT_CNT_W = 4;
    localparam logic [LAT_CNT_W-1:0] LAT_ONE = LAT_CNT_W'(1);

    // Read-side handshake states
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_VALID = 2'd2,
        R_ACK   = 2'd3
    } rdState_t;

    // Write-side handshake states
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_ACK  = 2'd2
    } wrState_t;

    // Increment that sticks at all-ones instead of wrapping to zero
    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/acc_mem_ram.sv
// Word array behind the responder.
// One protocol write port, one host write port, a gated fetch read port
// feeding rd_data and a free-running host read port. Both read ports are
// registered and write-first: a write landing on the same index in the
// same cycle is what the read register captures. When both writers hit
// the same index in one cycle the protocol write wins and the host write
// is dropped. The array itself has no reset so its contents survive one.
module acc_mem_ram
    import acc_mem_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              protoWe_i,
    input  logic [AW-1:0]     protoIdx_i,
    input  logic [DATA_W-1:0] protoData_i,
    input  logic              hostWe_i,
    input  logic [AW-1:0]     hostIdx_i,
    input  logic [DATA_W-1:0] hostData_i,
    input  logic              fetchEn_i,
    input  logic [AW-1:0]     fetchIdx_i,
    output logic [DATA_W-1:0] fetchData_o,
    input  logic [AW-1:0]     hostRdIdx_i,
    output logic [DATA_W-1:0] hostRdData_o
);

    localparam int DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              hostWeEff;
    logic [DATA_W-1:0] fetchData_d;
    logic [DATA_W-1:0] fetchData_q;
    logic [DATA_W-1:0] hostRdData_d;
    logic [DATA_W-1:0] hostRdData_q;

    // A host write colliding with a protocol write to the same index is dropped
    assign hostWeEff = hostWe_i && !(protoWe_i && (hostIdx_i == protoIdx_i));

    // Commit the protocol and host writes into the array
    always_ff @(posedge clk) begin
        if (protoWe_i) begin
            mem[protoIdx_i] <= protoData_i;
        end
        if (hostWeEff) begin
            mem[hostIdx_i] <= hostData_i;
        end
    end

    // Write-first bypass so a read in the commit cycle sees the new word
    always_comb begin
        fetchData_d = mem[fetchIdx_i];
        if (protoWe_i && (protoIdx_i == fetchIdx_i)) begin
            fetchData_d = protoData_i;
        end else if (hostWeEff && (hostIdx_i == fetchIdx_i)) begin
            fetchData_d = hostData_i;
        end

        hostRdData_d = mem[hostRdIdx_i];
        if (protoWe_i && (protoIdx_i == hostRdIdx_i)) begin
            hostRdData_d = protoData_i;
        end else if (hostWeEff && (hostIdx_i == hostRdIdx_i)) begin
            hostRdData_d = hostData_i;
        end
    end

    // Read registers: the fetch word holds until the next fetch, host port reloads every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchData_q  <= '0;
            hostRdData_q <= '0;
        end else begin
            if (fetchEn_i) begin
                fetchData_q <= fetchData_d;
            end
            hostRdData_q <= hostRdData_d;
        end
    end

    assign fetchData_o  = fetchData_q;
    assign hostRdData_o = hostRdData_q;

endmodule

// File: rtl/acc_mem_responder.sv
// Accelerator-side memory responder.
// Serves word reads and writes from an initiator using a ready/finish
// handshake with configurable fixed latencies, exposes a host port for
// preload and inspection, and reports busy status.
// Optional feature macro: ACC_MEM_RSP_STATS_EN -- when defined, rd_count and
// wr_count are saturating counts of rd_ready/wr_ready pulses; when undefined
// the counters are not built and both outputs read zero.
module acc_mem_responder
    import acc_mem_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic [ADDR_W-1:0]  rd_size,
    input  logic               rd_finish,
    output logic [DATA_W-1:0]  rd_data,
    output logic [READY_W-1:0] rd_ready,

    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0]  wr_size,
    input  logic               wr_finish,
    output logic [READY_W-1:0] wr_ready,

    input  logic               host_we,
    input  logic [MEM_AW-1:0]  host_addr,
    input  logic [DATA_W-1:0]  host_wdata,
    output logic [DATA_W-1:0]  host_rdata,
    output logic               busy,

    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count
);

    // Counter load values: the counter hits zero in the cycle whose edge
    // completes the requested latency measured from the capture edge
    localparam logic [LAT_CNT_W-1:0] RD_LOAD = LAT_CNT_W'(RD_LAT - 1);
    localparam logic [LAT_CNT_W-1:0] WR_LOAD = LAT_CNT_W'(WR_LAT - 1);

    rdState_t               rdState_q;
    logic [LAT_CNT_W-1:0]   rdCnt_q;
    logic [MEM_AW-1:0]      rdIdx_q;
    logic                   rdReady_q;

    wrState_t               wrState_q;
    logic [LAT_CNT_W-1:0]   wrCnt_q;
    logic [MEM_AW-1:0]      wrIdx_q;
    logic [DATA_W-1:0]      wrData_q;
    logic                   wrReady_q;

    logic                   rdFetch;
    logic                   wrCommit;
    logic                   hostWeGated;
    logic [DATA_W-1:0]      fetchData;
    logic [DATA_W-1:0]      hostRdData;

    // Size ports and out-of-range address bits are intentionally ignored:
    // the initiator owns the stride and addresses wrap on the word array
    logic                   unusedBits;
    assign unusedBits = ^{rd_size, wr_size,
                          rd_addr[ADDR_W-1:MEM_AW+2], rd_addr[1:0],
                          wr_addr[ADDR_W-1:MEM_AW+2], wr_addr[1:0]};

    assign rdFetch     = (rdState_q == R_WAIT) && (rdCnt_q == '0);
    assign wrCommit    = (wrState_q == W_WAIT) && (wrCnt_q == '0) && !reset;
    assign hostWeGated = host_we && !reset;

    // Read handshake FSM with registered rd_ready pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdState_q <= R_IDLE;
            rdCnt_q   <= '0;
            rdIdx_q   <= '0;
            rdReady_q <= 1'b0;
        end else begin
            rdReady_q <= 1'b0;
            unique case (rdState_q)
                R_IDLE: begin
                    if (rd_en) begin
                        rdIdx_q   <= rd_addr[MEM_AW+1:2];
                        rdCnt_q   <= RD_LOAD;
                        rdState_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rdCnt_q == '0) begin
                        rdReady_q <= 1'b1;
                        rdState_q <= R_VALID;
                    end else begin
                        rdCnt_q <= rdCnt_q - LAT_ONE;
                    end
                end
                R_VALID: begin
                    rdState_q <= R_ACK;
                end
                R_ACK: begin
                    if (rd_finish) begin
                        rdIdx_q   <= rd_addr[MEM_AW+1:2];
                        rdCnt_q   <= RD_LOAD;
                        rdState_q <= R_WAIT;
                    end else if (!rd_en) begin
                        rdState_q <= R_IDLE;
                    end
                end
                default: begin
                    rdState_q <= R_IDLE;
                end
            endcase
        end
    end

    // Write handshake FSM; the memory commit coincides with the wr_ready rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrState_q <= W_IDLE;
            wrCnt_q   <= '0;
            wrIdx_q   <= '0;
            wrData_q  <= '0;
            wrReady_q <= 1'b0;
        end else begin
            wrReady_q <= 1'b0;
            unique case (wrState_q)
                W_IDLE: begin
                    if (wr_en) begin
                        wrIdx_q   <= wr_addr[MEM_AW+1:2];
                        wrData_q  <= wr_data;
                        wrCnt_q   <= WR_LOAD;
                        wrState_q <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (wrCnt_q == '0) begin
                        wrReady_q <= 1'b1;
                        wrState_q <= W_ACK;
                    end else begin
                        wrCnt_q <= wrCnt_q - LAT_ONE;
                    end
                end
                W_ACK: begin
                    if (wr_finish) begin
                        wrIdx_q   <= wr_addr[MEM_AW+1:2];
                        wrData_q  <= wr_data;
                        wrCnt_q   <= WR_LOAD;
                        wrState_q <= W_WAIT;
                    end else if (!wr_en) begin
                        wrState_q <= W_IDLE;
                    end
                end
                default: begin
                    wrState_q <= W_IDLE;
                end
            endcase
        end
    end

    acc_mem_ram #(
        .AW (MEM_AW)
    ) u_ram (
        .clk          (clk),
        .reset        (reset),
        .protoWe_i    (wrCommit),
        .protoIdx_i   (wrIdx_q),
        .protoData_i  (wrData_q),
        .hostWe_i     (hostWeGated),
        .hostIdx_i    (host_addr),
        .hostData_i   (host_wdata),
        .fetchEn_i    (rdFetch),
        .fetchIdx_i   (rdIdx_q),
        .fetchData_o  (fetchData),
        .hostRdIdx_i  (host_addr),
        .hostRdData_o (hostRdData)
    );

    assign rd_data    = fetchData;
    assign host_rdata = hostRdData;
    assign rd_ready   = {{(READY_W-1){1'b0}}, rdReady_q};
    assign wr_ready   = {{(READY_W-1){1'b0}}, wrReady_q};
    assign busy       = (rdState_q != R_IDLE) || (wrState_q != W_IDLE);

`ifdef ACC_MEM_RSP_STATS_EN
    logic [31:0] rdCount_q;
    logic [31:0] wrCount_q;

    // Saturating tallies of completed read and write words
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdCount_q <= '0;
            wrCount_q <= '0;
        end else begin
            if (rdReady_q) begin
                rdCount_q <= satInc(rdCount_q);
            end
            if (wrReady_q) begin
                wrCount_q <= satInc(wrCount_q);
            end
        end
    end

    assign rd_count = rdCount_q;
    assign wr_count = wrCount_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: doc/acc_mem_responder.md
ACC_MEM_RESPONDER -- requirements
Module: acc_mem_responder

Interface
REQ-001 SHALL have parameter MEM_AW, 10, word-address width; memory holds 2^MEM_AW 32-bit words.
REQ-002 SHALL have parameter RD_LAT, 2, cycles from read address capture to rd_ready pulse; range 1..15.
REQ-003 SHALL have parameter WR_LAT, 1, cycles from write capture to memory commit and wr_ready pulse; range 1..15.
REQ-004 SHALL have ports: clk in 1 clock; reset in 1 (reset reset, asynchronous, active-high; clock clk).
REQ-005 SHALL have read ports: rd_en in 1; rd_addr in 64 byte address; rd_size in 64 (unused, stride owned by initiator); rd_finish in 1 word-accepted pulse; rd_data out 32; rd_ready out 64, value 0 or 1 only.
REQ-006 SHALL have write ports: wr_en in 1; wr_addr in 64; wr_data in 32; wr_size in 64 (unused); wr_finish in 1; wr_ready out 64, value 0 or 1 only.
REQ-007 SHALL have host ports: host_we in 1; host_addr in MEM_AW; host_wdata in 32; host_rdata out 32; busy out 1.
REQ-008 SHALL have stat ports: rd_count out 32; wr_count out 32.

Function
REQ-009 SHALL map byte address A to word index A[MEM_AW+1:2]; higher bits ignored (wrap-around).
REQ-010 Read FSM SHALL have states R_IDLE, R_WAIT, R_VALID, R_ACK.
REQ-011 R_IDLE: rd_en=1 -> capture rd_addr, load latency counter, go R_WAIT.
REQ-012 R_WAIT: after RD_LAT cycles total from capture, register memory word to rd_data, go R_VALID.
REQ-013 R_VALID SHALL last exactly one cycle with rd_ready=1, then R_ACK; rd_ready is a single-cycle pulse per word.
REQ-014 R_ACK: rd_finish=1 -> capture current rd_addr (already advanced), go R_WAIT; else rd_en=0 -> R_IDLE; else hold.
REQ-015 rd_data SHALL hold its value until the next fetch.
REQ-016 Write FSM SHALL have states W_IDLE, W_WAIT, W_ACK.
REQ-017 W_IDLE: wr_en=1 -> capture wr_addr and wr_data, go W_WAIT.
REQ-018 W_WAIT: after WR_LAT cycles commit word to memory and pulse wr_ready=1 for one cycle, go W_ACK.
REQ-019 W_ACK: wr_finish=1 -> capture wr_addr/wr_data, go W_WAIT; else wr_en=0 -> W_IDLE; else hold.
REQ-020 Same-cycle protocol write commit and read fetch to one index SHALL return the new data (write-first).
REQ-021 Host write SHALL be ignored when colliding with a protocol write to the same index in the same cycle; otherwise host write commits that cycle.
REQ-022 host_rdata SHALL equal memory[host_addr] one cycle after host_addr is sampled.
REQ-023 busy SHALL be 1 whenever either FSM is not idle.
REQ-024 rd_count/wr_count SHALL increment on each rd_ready/wr_ready pulse, saturating at 0xFFFFFFFF.

Reset
REQ-025 Reset SHALL force R_IDLE, W_IDLE, rd_ready=0, wr_ready=0, rd_data=0, host_rdata=0, busy=0, counters=0, latency counters=0.
REQ-026 Reset mid-transfer SHALL abort without committing a pending write; memory contents SHALL be preserved.

Configuration
REQ-027 Macro ACC_MEM_RSP_STATS_EN defined: rd_count/wr_count implemented per REQ-024.
REQ-028 Macro ACC_MEM_RSP_STATS_EN undefined: counter registers absent, rd_count/wr_count tied to 0; ports remain.

Structure
REQ-029 Package acc_mem_pkg SHALL hold read/write FSM state enums, DATA_W=32, ADDR_W=64, READY_W=64 constants.
REQ-030 Sub-module acc_mem_ram SHALL implement the word array: one protocol write port, one host write port, two read ports.

Verification
REQ-031 Host preloads words 0..3 = 0x11,0x22,0x33,0x44; rd_en with rd_addr=0, finish per word, addr+4, rd_en drop after 4th -> rd_data 0x11..0x44, each rd_ready single-cycle, first ready 2 cycles after capture.
REQ-032 wr_en with wr_addr=0x40, data 0xA5A5A5A5 then 0x5A5A5A5A via wr_finish -> host_rdata at index 16,17 reads those values; wr_count=2 (stats on).
REQ-033 rd_addr=0x1000 with MEM_AW=10 -> returns word at index 0 (wrap).
REQ-034 Protocol write 0xDEAD and host write 0xBEEF to index 5 same cycle -> index 5 = 0xDEAD.
REQ-035 Reset asserted in R_WAIT and W_WAIT -> next cycle rd_ready=0, wr_ready=0, busy=0; pending write absent from memory, earlier words intact.
REQ-036 Build without ACC_MEM_RSP_STATS_EN, run REQ-031 -> rd_count=0, data identical.
